// File: rtl/bank_config_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bank_config_pkg
// Description : Shared state encoding and sizing helpers for the bank loader.
// Revision    : 1.0 - initial release
// ============================================================================
package bank_config_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SETUP = 3'd2,
        ST_PULSE = 3'd3,
        ST_HOLD  = 3'd4,
        ST_DONE  = 3'd5
    } cfg_state_t;

    function automatic int words_per_row(input int bl, input int dw);
        return (bl + dw - 1) / dw;
    endfunction

    // Width able to hold 0..n-1, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bl_row_assembler.sv
`default_nettype none
// ============================================================================
// Module      : bl_row_assembler
// Description : Builds one bit-line row from indexed words; the top word is
//               truncated at BL_WIDTH.
// Revision    : 1.0 - initial release
// ============================================================================
module bl_row_assembler
    import bank_config_pkg::*;
#(
    parameter int BL_WIDTH   = 315,
    parameter int DATA_WIDTH = 32
) (
    input  logic                                                        clk,
    input  logic                                                        reset,
    input  logic                                                        wr_en,
    input  logic [clog2_min1(words_per_row(BL_WIDTH, DATA_WIDTH))-1:0]  wr_idx,
    input  logic [DATA_WIDTH-1:0]                                       wr_data,
    input  logic                                                        clear,
    output logic [BL_WIDTH-1:0]                                         row
);

    localparam int C_WPR   = words_per_row(BL_WIDTH, DATA_WIDTH);
    localparam int C_IDX_W = clog2_min1(C_WPR);

    // One register slice per word; the last slice is only as wide as the
    // bits left in the row, so overflow bits of the top word never land.
    for (genvar k = 0; k < C_WPR; k++) begin : g_word
        localparam int C_LO = k * DATA_WIDTH;
        localparam int C_W  = (C_LO + DATA_WIDTH > BL_WIDTH) ? (BL_WIDTH - C_LO) : DATA_WIDTH;

        logic [C_W-1:0] r_slice;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_slice <= '0;
            end else if (clear) begin
                r_slice <= '0;
            end else if (wr_en && (wr_idx == C_IDX_W'(k))) begin
                r_slice <= wr_data[C_W-1:0];
            end
        end

        assign row[C_LO +: C_W] = r_slice;
    end

endmodule
`default_nettype wire

// File: rtl/bank_config_loader.sv
`default_nettype none
// ============================================================================
// Module      : bank_config_loader
// Description : Streams a bitstream into bit-line rows and strobes one word
//               line per row across the whole tile memory bank.
// Revision    : 1.0 - initial release
// ============================================================================
module bank_config_loader
    import bank_config_pkg::*;
#(
    parameter int BL_WIDTH   = 315,
    parameter int WL_WIDTH   = 4,
    parameter int DATA_WIDTH = 32,
    parameter int WL_PULSE   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [BL_WIDTH-1:0]   bl_out,
    output logic [WL_WIDTH-1:0]   wl_out,
    output logic                  busy,
    output logic                  done
);

    localparam int C_WPR     = words_per_row(BL_WIDTH, DATA_WIDTH);
    localparam int C_WCNT_W  = clog2_min1(C_WPR);
    localparam int C_ROW_W   = clog2_min1(WL_WIDTH);
    localparam int C_PULSE_W = clog2_min1(WL_PULSE);

    cfg_state_t            r_state;
    logic [C_WCNT_W-1:0]   r_word_cnt;
    logic [C_ROW_W-1:0]    r_row;
    logic [C_PULSE_W-1:0]  r_pulse_cnt;
    logic [WL_WIDTH-1:0]   r_wl;
    logic                  r_busy;
    logic                  r_done;

    logic w_xfer;
    logic w_last_word;
    logic w_last_row;
    logic w_last_pulse;
    logic w_row_clear;

    // A word arriving in the same cycle as abort is refused outright.
    assign in_ready     = (r_state == ST_LOAD) && !abort;
    assign w_xfer       = in_valid && in_ready;
    assign w_last_word  = (r_word_cnt == C_WCNT_W'(C_WPR - 1));
    assign w_last_row   = (r_row == C_ROW_W'(WL_WIDTH - 1));
    assign w_last_pulse = (r_pulse_cnt == C_PULSE_W'(WL_PULSE - 1));
    assign w_row_clear  = abort || ((r_state == ST_HOLD) && w_last_row);

    bl_row_assembler #(
        .BL_WIDTH   (BL_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_row (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (w_xfer),
        .wr_idx  (r_word_cnt),
        .wr_data (in_data),
        .clear   (w_row_clear),
        .row     (bl_out)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_word_cnt  <= '0;
            r_row       <= '0;
            r_pulse_cnt <= '0;
            r_wl        <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else if (abort) begin
            r_state     <= ST_IDLE;
            r_word_cnt  <= '0;
            r_row       <= '0;
            r_pulse_cnt <= '0;
            r_wl        <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state    <= ST_LOAD;
                        r_row      <= '0;
                        r_word_cnt <= '0;
                        r_busy     <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (w_xfer) begin
                        if (w_last_word) begin
                            r_state <= ST_SETUP;
                        end else begin
                            r_word_cnt <= r_word_cnt + C_WCNT_W'(1);
                        end
                    end
                end
                ST_SETUP: begin
                    r_state     <= ST_PULSE;
                    r_wl        <= WL_WIDTH'(1) << r_row;
                    r_pulse_cnt <= '0;
                end
                ST_PULSE: begin
                    if (w_last_pulse) begin
                        r_state <= ST_HOLD;
                        r_wl    <= '0;
                    end else begin
                        r_pulse_cnt <= r_pulse_cnt + C_PULSE_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (w_last_row) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_state    <= ST_LOAD;
                        r_row      <= r_row + C_ROW_W'(1);
                        r_word_cnt <= '0;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_wl    <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign wl_out = r_wl;
    assign busy   = r_busy;
    assign done   = r_done;

endmodule
`default_nettype wire

// File: tb/tb_bank_config_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_bank_config_loader
// Description : Directed self-checking bench with a word-queue row model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bank_config_loader;

    localparam int BL  = 315;
    localparam int DW  = 32;
    localparam int WLW = 4;
    localparam int WPR = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        start, abort, in_valid, in_ready, busy, done;
    logic [31:0] in_data;
    logic [BL-1:0]  bl_out;
    logic [WLW-1:0] wl_out;

    logic        p_start, p_abort, p_valid, p_ready, p_busy, p_done;
    logic [31:0] p_data;
    logic [BL-1:0] p_bl;
    logic [0:0]    p_wl;

    bank_config_loader #(.BL_WIDTH(BL), .WL_WIDTH(WLW), .DATA_WIDTH(DW), .WL_PULSE(2)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .bl_out(bl_out), .wl_out(wl_out), .busy(busy), .done(done)
    );

    bank_config_loader #(.BL_WIDTH(BL), .WL_WIDTH(1), .DATA_WIDTH(DW), .WL_PULSE(1)) dut_p (
        .clk(clk), .reset(reset), .start(p_start), .abort(p_abort),
        .in_data(p_data), .in_valid(p_valid), .in_ready(p_ready),
        .bl_out(p_bl), .wl_out(p_wl), .busy(p_busy), .done(p_done)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int t_s1, t_s2;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [319:0] act, input logic [319:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model: every accepted word, in order; row r is words r*WPR.. laid out LSB first.
    logic [31:0] q1[$];
    logic [31:0] q2[$];

    function automatic logic [319:0] model_row(input int sel, input int r);
        logic [319:0] v;
        logic [31:0]  wd;
        int           w;
        v = '0;
        for (int b = 0; b < BL; b++) begin
            w = r * WPR + b / DW;
            if (sel == 1 && w >= 0 && w < q1.size()) begin
                wd = q1[w];
                v[b] = wd[b % DW];
            end else if (sel == 2 && w >= 0 && w < q2.size()) begin
                wd = q2[w];
                v[b] = wd[b % DW];
            end
        end
        return v;
    endfunction

    logic [BL-1:0]  snap[8];
    logic [WLW-1:0] wl_seen[8];
    int             wl_len[8];
    int             npulse = 0;

    logic [WLW-1:0] prev_wl = '0;
    logic [BL-1:0]  prev_bl = '0;
    logic [0:0]     prev_pwl = '0;
    logic [BL-1:0]  prev_pbl = '0;
    logic           edge_abort1 = 1'b0;
    logic           edge_abort2 = 1'b0;
    int             r1, r2;
    logic [WLW-1:0] exp_wl;

    always @(posedge clk) begin
        edge_abort1 <= abort;
        edge_abort2 <= p_abort;
    end

    // Compare process: checks both DUTs against the queue model each cycle.
    always @(negedge clk) begin
        if (reset) begin
            if (start && !busy) begin
                q1.delete();
                npulse = 0;
            end
            if (in_valid && in_ready) q1.push_back(in_data);
            chk("wl_onehot0", $onehot0(wl_out), 1);
            if (prev_wl != 0 && !edge_abort1) chk("bl_stable_under_wl", bl_out, prev_bl);
            if (wl_out != 0) begin
                r1 = q1.size() / WPR - 1;
                exp_wl = '0;
                if (r1 >= 0 && r1 < WLW) exp_wl[r1] = 1'b1;
                chk("wl_row", wl_out, exp_wl);
                chk("bl_row_data", bl_out, model_row(1, r1));
                if (prev_wl == 0 && npulse < 8) begin
                    snap[npulse]    = bl_out;
                    wl_seen[npulse] = wl_out;
                    wl_len[npulse]  = 1;
                    npulse++;
                end else if (npulse > 0) begin
                    wl_len[npulse-1]++;
                end
            end
            if (done) begin
                chk("done_words", q1.size(), WPR * WLW);
                chk("done_wl", wl_out, 0);
                chk("done_bl", bl_out, 0);
            end

            if (p_start && !p_busy) q2.delete();
            if (p_valid && p_ready) q2.push_back(p_data);
            if (prev_pwl != 0 && !edge_abort2) chk("p_bl_stable_under_wl", p_bl, prev_pbl);
            if (p_wl != 0) begin
                r2 = q2.size() / WPR - 1;
                chk("p_wl_row", p_wl, (r2 == 0) ? 1 : 0);
                chk("p_bl_row_data", p_bl, model_row(2, r2));
            end
            if (p_done) chk("p_done_words", q2.size(), WPR);
        end
        prev_wl  = wl_out;
        prev_bl  = bl_out;
        prev_pwl = p_wl;
        prev_pbl = p_bl;
    end

    task automatic do_start(input int sel);
        @(posedge clk);
        #1;
        if (sel == 1) start = 1'b1; else p_start = 1'b1;
        @(posedge clk);
        #1;
        if (sel == 1) begin start = 1'b0; t_s1 = cyc; end
        else begin p_start = 1'b0; t_s2 = cyc; end
    endtask

    task automatic push(input int sel, input logic [31:0] d);
        logic got;
        int   n;
        got = 1'b0;
        n = 0;
        if (sel == 1) begin in_data = d; in_valid = 1'b1; end
        else begin p_data = d; p_valid = 1'b1; end
        while (!got && n < 100) begin
            @(negedge clk);
            got = (sel == 1) ? in_ready : p_ready;
            @(posedge clk);
            #1;
            n++;
        end
        chk("push_accept", got, 1);
    endtask

    task automatic wait_done(input int sel, input int exp_diff);
        logic found;
        int   dc;
        found = 1'b0;
        dc = 0;
        for (int n = 0; n < 300 && !found; n++) begin
            @(negedge clk);
            if ((sel == 1) ? done : p_done) begin
                found = 1'b1;
                dc = cyc;
            end
        end
        chk("done_seen", found, 1);
        chk("done_cycle", dc - ((sel == 1) ? t_s1 : t_s2), exp_diff);
        @(negedge clk);
        chk("busy_after_done", (sel == 1) ? busy : p_busy, 0);
    endtask

    logic [WLW-1:0] exp_seq[4];
    logic [BL-1:0]  bl_hold;
    logic           seen;

    initial begin
        exp_seq[0] = 4'b0001; exp_seq[1] = 4'b0010;
        exp_seq[2] = 4'b0100; exp_seq[3] = 4'b1000;
        reset = 1'b1;
        start = 0; abort = 0; in_valid = 0; in_data = '0;
        p_start = 0; p_abort = 0; p_valid = 0; p_data = '0;
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        chk("rst_bl", bl_out, 0);
        chk("rst_wl", wl_out, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        @(negedge clk);
        reset = 1'b1;

        // Full load, word i = i
        do_start(1);
        chk("start_busy", busy, 1);
        chk("start_in_ready", in_ready, 1);
        for (int i = 0; i < 40; i++) push(1, i);
        in_valid = 1'b0;
        wait_done(1, 56);
        chk("npulse", npulse, 4);
        for (int k = 0; k < 4; k++) begin
            chk("wl_seq", wl_seen[k], exp_seq[k]);
            chk("wl_len", wl_len[k], 2);
        end
        chk("row0_word0", snap[0][31:0], 0);
        chk("row0_word1", snap[0][63:32], 1);
        chk("row3_word0", snap[3][31:0], 30);
        chk("row3_word9", snap[3][314:288], 39);

        // Stall after word 3 of row 1
        do_start(1);
        for (int i = 0; i < 40; i++) begin
            push(1, i);
            if (i == 13) begin
                in_valid = 1'b0;
                bl_hold = bl_out;
                repeat (5) begin
                    @(negedge clk);
                    chk("stall_in_ready", in_ready, 1);
                    chk("stall_bl", bl_out, bl_hold);
                    @(posedge clk);
                    #1;
                end
            end
        end
        in_valid = 1'b0;
        wait_done(1, 61);
        chk("stall_row1_w3", snap[1][127:96], 13);
        chk("stall_row1_w4", snap[1][159:128], 14);

        // Truncation of word 9
        do_start(1);
        for (int i = 0; i < 40; i++) push(1, (i == 9) ? 32'hFFFF_FFFF : 32'h0);
        in_valid = 1'b0;
        wait_done(1, 56);
        chk("trunc_top", snap[0][314:288], 27'h7FF_FFFF);
        chk("trunc_low", snap[0][287:0], 0);
        chk("trunc_no_x", $isunknown(snap[0]), 0);
        chk("trunc_row1", snap[1], 0);

        // Abort during PULSE of row 2
        do_start(1);
        for (int i = 0; i < 30; i++) push(1, i + 1000);
        in_valid = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            if (wl_out == 4'b0100) seen = 1'b1;
        end
        chk("abort_reach_pulse", wl_out, 4'b0100);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        chk("abort_wl", wl_out, 0);
        chk("abort_bl", bl_out, 0);
        chk("abort_busy", busy, 0);
        chk("abort_in_ready", in_ready, 0);
        repeat (5) begin
            @(negedge clk);
            chk("abort_no_done", done, 0);
        end

        // Abort while a word is offered in LOAD
        do_start(1);
        push(1, 100);
        push(1, 101);
        in_data = 102;
        in_valid = 1'b1;
        #1 abort = 1'b1;
        @(negedge clk);
        chk("abort_refuses_word", in_ready, 0);
        @(posedge clk);
        #1;
        abort = 1'b0;
        in_valid = 1'b0;
        chk("abort_load_busy", busy, 0);
        chk("abort_load_bl", bl_out, 0);

        // Clean reload after abort
        do_start(1);
        for (int i = 0; i < 40; i++) push(1, i * 3 + 7);
        in_valid = 1'b0;
        wait_done(1, 56);
        chk("reload_first_wl", wl_seen[0], 4'b0001);
        chk("reload_row0_w0", snap[0][31:0], 7);
        chk("reload_row2_w1", snap[2][63:32], 70);

        // Asynchronous reset mid-LOAD, start held during reset
        do_start(1);
        push(1, 5);
        push(1, 6);
        push(1, 7);
        chk("pre_reset_bl_loaded", bl_out[95:0], {32'd7, 32'd6, 32'd5});
        #3;
        reset = 1'b0;
        start = 1'b1;
        #1;
        chk("areset_bl", bl_out, 0);
        chk("areset_wl", wl_out, 0);
        chk("areset_in_ready", in_ready, 0);
        chk("areset_busy", busy, 0);
        chk("areset_done", done, 0);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("areset_held_busy", busy, 0);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("post_reset_idle", busy, 0);
        end

        // WL_WIDTH=1, WL_PULSE=1 instance; start while busy must be ignored
        do_start(2);
        for (int i = 0; i < 10; i++) begin
            if (i == 4) p_start = 1'b1;
            push(2, i + 200);
            p_start = 1'b0;
        end
        p_valid = 1'b0;
        wait_done(2, 13);
        repeat (3) begin
            @(negedge clk);
            chk("p_idle_after_done", p_busy, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
